// File: rtl/lcd_bus_sched.sv
// LCD bus scheduler: merges a pixel-streamer write path with a FIFO of host
// command bytes onto one registered LCD bus. Pixel writes always win. Host
// bytes go out in atomic groups, only during vblank, with one idle bus cycle
// after every host write.
module lcd_bus_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       px_write,
  input  logic [7:0] px_data,
  input  logic       px_cd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_cd,
  input  logic       cmd_last,
  output logic [7:0] lcd_data,
  output logic       lcd_cd,
  output logic       lcd_write,
  output logic       cmd_pending
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // FIFO entry layout: {cd, last, data[7:0]}
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [AW:0]   r_groups;
  logic          r_last_issued;

  logic          r_lcd_write;
  logic [7:0]    r_lcd_data;
  logic          r_lcd_cd;

  logic          w_full;
  logic          w_accept;
  logic          w_pop;
  logic          w_bus_busy;
  logic [9:0]    w_head;
  logic          w_head_last;
  logic          w_grp_inc;
  logic          w_grp_dec;

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  // Held low during reset so nothing can be pushed while the FIFO is cleared.
  assign cmd_ready   = ~reset & ~w_full;
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_head      = r_mem[r_rptr];
  assign w_head_last = w_head[8];
  // The bus is taken if a pixel write is being requested now or a write is
  // on the bus this cycle (the latter enforces the idle cycle between writes).
  assign w_bus_busy  = px_write | r_lcd_write;
  assign w_grp_inc   = w_accept & cmd_last;
  assign w_grp_dec   = w_pop & w_head_last;

  assign lcd_write   = r_lcd_write;
  assign lcd_data    = r_lcd_data;
  assign lcd_cd      = r_lcd_cd;
  assign cmd_pending = (r_count != '0);

  // Host scheduler next state; a group only starts once its last byte is
  // queued, then runs to completion regardless of vblank.
  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (vblank && (r_groups != '0) && !w_bus_busy)
          w_state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_count == '0)
          w_state_nx = S_IDLE;
        else if (!w_bus_busy) begin
          w_pop      = 1'b1;
          w_state_nx = S_GAP;
        end
      end
      S_GAP: begin
        w_state_nx = r_last_issued ? S_IDLE : S_ISSUE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Scheduler state register and the last-flag of the byte just issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_issued <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_pop)
        r_last_issued <= w_head_last;
    end
  end

  // FIFO pointers, occupancy and complete-group count; push and pop may
  // happen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_groups <= '0;
    end else begin
      if (w_accept)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      r_count  <= r_count + (AW+1)'(w_accept) - (AW+1)'(w_pop);
      r_groups <= r_groups + (AW+1)'(w_grp_inc) - (AW+1)'(w_grp_dec);
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_mem[r_wptr] <= {cmd_cd, cmd_last, cmd_data};
  end

  // Registered LCD bus: pixel bytes take priority, host bytes fill idle slots,
  // data/cd hold their value when no write is strobed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lcd_write <= 1'b0;
      r_lcd_data  <= 8'h00;
      r_lcd_cd    <= 1'b0;
    end else begin
      r_lcd_write <= px_write | w_pop;
      if (px_write) begin
        r_lcd_data <= px_data;
        r_lcd_cd   <= px_cd;
      end else if (w_pop) begin
        r_lcd_data <= w_head[7:0];
        r_lcd_cd   <= w_head[9];
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Directed bench for lcd_bus_sched: expected bus writes are queued by the
// stimulus, a monitor pops and compares every strobed LCD write.
module tb_lcd_bus_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vblank = 1'b0;
  logic       px_write = 1'b0;
  logic [7:0] px_data = 8'h00;
  logic       px_cd = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_cd = 1'b0;
  logic       cmd_last = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_cd;
  logic       lcd_write;
  logic       cmd_pending;

  lcd_bus_sched #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .px_write(px_write), .px_data(px_data), .px_cd(px_cd),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_cd(cmd_cd), .cmd_last(cmd_last),
    .lcd_data(lcd_data), .lcd_cd(lcd_cd), .lcd_write(lcd_write),
    .cmd_pending(cmd_pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_wr = 0;
  int prev_wr = 0;
  logic fifth_done = 1'b0;

  logic [8:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (lcd_write === 1'b1) begin
      logic [8:0] e;
      wr_count = wr_count + 1;
      prev_wr  = last_wr;
      last_wr  = cyc;
      n_vec    = n_vec + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_write: got cd=%0d data=0x%02h, want no write", lcd_cd, lcd_data);
      end else begin
        e = exp_q.pop_front();
        if ({lcd_cd, lcd_data} !== e) begin
          n_err = n_err + 1;
          $display("FAIL lcd_bus_out: got cd=%0d data=0x%02h, want cd=%0d data=0x%02h",
                   lcd_cd, lcd_data, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic cd, input logic last, input logic [7:0] data);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    step();
    cmd_valid = 1'b1;
    cmd_cd    = cd;
    cmd_last  = last;
    cmd_data  = data;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = cmd_ready;
      step();
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      look();
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [7:0] pix [3];
    pix[0] = 8'h3C; pix[1] = 8'h00; pix[2] = 8'hFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    look();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_lcd_write", lcd_write, 0);
    chk("rst_lcd_data", lcd_data, 8'h00);
    chk("rst_lcd_cd", lcd_cd, 0);
    chk("rst_pending", cmd_pending, 0);
    step();
    reset = 1'b0;
    look();
    chk("post_rst_ready", cmd_ready, 1);

    // Pixel pass-through with one-cycle latency
    step();
    vblank = 1'b0; px_write = 1'b1; px_data = 8'hA5; px_cd = 1'b1;
    exp_q.push_back({1'b1, 8'hA5});
    look();
    chk("px_not_early", lcd_write, 0);
    step();
    px_write = 1'b0;
    look();
    chk("px_n1_write", lcd_write, 1);
    chk("px_n1_data", lcd_data, 8'hA5);
    chk("px_n1_cd", lcd_cd, 1);
    step();
    look();
    chk("px_n2_write", lcd_write, 0);
    chk("px_hold_data", lcd_data, 8'hA5);

    // Back-to-back pixel writes
    for (int i = 0; i < 3; i++) begin
      step();
      px_write = 1'b1; px_data = pix[i]; px_cd = i[0];
      exp_q.push_back({i[0], pix[i]});
    end
    step();
    px_write = 1'b0;
    wait_drain("px_burst_drain", 10);

    // Host group 0x81, 0x00 issued in vblank with one idle cycle between
    base = wr_count;
    push(1'b0, 1'b0, 8'h81);
    push(1'b0, 1'b1, 8'h00);
    look();
    chk("grp_pending", cmd_pending, 1);
    chk("grp_no_issue_active", wr_count, base);
    exp_q.push_back({1'b0, 8'h81});
    exp_q.push_back({1'b0, 8'h00});
    step();
    vblank = 1'b1;
    wait_drain("grp_drain", 20);
    chk("grp_gap", last_wr - prev_wr, 2);
    look();
    chk("grp_pending_clear", cmd_pending, 0);

    // Incomplete group waits for its last byte
    base = wr_count;
    push(1'b0, 1'b0, 8'h81);
    repeat (50) look();
    chk("incomplete_no_write", wr_count, base);
    chk("incomplete_pending", cmd_pending, 1);
    exp_q.push_back({1'b0, 8'h81});
    exp_q.push_back({1'b0, 8'h46});
    push(1'b0, 1'b1, 8'h46);
    wait_drain("incomplete_drain", 20);
    chk("incomplete_gap", last_wr - prev_wr, 2);
    repeat (3) look();

    // Collision: pixel write arrives while a host byte is due in ISSUE
    exp_q.push_back({1'b1, 8'h5A});
    exp_q.push_back({1'b1, 8'h3C});
    push(1'b1, 1'b1, 8'h3C);
    step();
    px_write = 1'b1; px_data = 8'h5A; px_cd = 1'b1;
    step();
    px_write = 1'b0;
    look();
    chk("coll_px_write", lcd_write, 1);
    chk("coll_px_data", lcd_data, 8'h5A);
    wait_drain("coll_drain", 20);
    chk("coll_host_delay", last_wr - prev_wr, 2);
    repeat (3) look();

    // Full FIFO: fifth byte is held until the first pop
    step();
    vblank = 1'b0;
    push(1'b1, 1'b0, 8'h01);
    push(1'b1, 1'b0, 8'h02);
    push(1'b1, 1'b0, 8'h03);
    push(1'b1, 1'b1, 8'h04);
    look();
    chk("full_ready", cmd_ready, 0);
    chk("full_pending", cmd_pending, 1);
    for (int i = 1; i <= 5; i++) exp_q.push_back({1'b1, 8'(i)});
    fork
      begin
        push(1'b1, 1'b1, 8'h05);
        fifth_done = 1'b1;
      end
    join_none
    repeat (3) look();
    chk("full_ready_hold", cmd_ready, 0);
    chk("full_fifth_held", fifth_done, 0);
    base = wr_count;
    step();
    vblank = 1'b1;
    n = 0;
    while (wr_count == base && n < 10) begin
      look();
      n++;
    end
    chk("full_first_pop_seen", wr_count, base + 1);
    chk("full_fifth_not_before_pop", fifth_done, 0);
    wait_drain("full_drain", 60);
    chk("full_fifth_accepted", fifth_done, 1);
    repeat (3) look();

    // Reset in the middle of a group
    step();
    vblank = 1'b0;
    push(1'b0, 1'b0, 8'h81);
    push(1'b0, 1'b1, 8'h22);
    exp_q.push_back({1'b0, 8'h81});
    base = wr_count;
    step();
    vblank = 1'b1;
    n = 0;
    while (wr_count == base && n < 10) begin
      look();
      n++;
    end
    chk("rstmid_first_byte", wr_count, base + 1);
    step();
    reset = 1'b1;
    look();
    chk("rstmid_ready_low", cmd_ready, 0);
    step();
    reset = 1'b0;
    look();
    chk("rstmid_write", lcd_write, 0);
    chk("rstmid_pending", cmd_pending, 0);
    chk("rstmid_data", lcd_data, 8'h00);
    chk("rstmid_ready", cmd_ready, 1);
    repeat (10) look();
    chk("rstmid_no_second", wr_count, base + 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_bus_sched.md
LCD_BUS_SCHED -- requirements
Module: lcd_bus_sched

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, number of host command entries (power of two, 2..16).
REQ-002 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: vblank  input  1  high while the pixel streamer issues no pixel writes (host window).
REQ-005 SHALL have port: px_write  input  1  pixel streamer write request, one-cycle pulse.
REQ-006 SHALL have port: px_data  input  8  pixel byte (two 4-bit grey pixels).
REQ-007 SHALL have port: px_cd  input  1  C/D level for the pixel byte (1=data, 0=command).
REQ-008 SHALL have port: cmd_valid  input  1  host byte offered.
REQ-009 SHALL have port: cmd_ready  output  1  host byte accepted when cmd_valid and cmd_ready are both high.
REQ-010 SHALL have port: cmd_data  input  8  host byte.
REQ-011 SHALL have port: cmd_cd  input  1  C/D level for the host byte.
REQ-012 SHALL have port: cmd_last  input  1  marks the final byte of an atomic host group (e.g. 0x81 then gain value).
REQ-013 SHALL have port: lcd_data  output  8  registered LCD bus data.
REQ-014 SHALL have port: lcd_cd  output  1  registered LCD C/D line.
REQ-015 SHALL have port: lcd_write  output  1  registered one-cycle write strobe.
REQ-016 SHALL have port: cmd_pending  output  1  high while the FIFO holds at least one byte.

Function
REQ-017 SHALL store host bytes as {cd,last,data} in a FIFO of FIFO_DEPTH entries; cmd_ready = not full; accept and issue-pop in the same cycle SHALL both take effect.
REQ-018 SHALL track the number of complete groups (entries with last=1) in the FIFO, incremented on accept of a last byte and decremented on issue of a last byte.
REQ-019 SHALL forward a pixel write with one cycle latency: px_write at cycle n -> lcd_write=1, lcd_data=px_data, lcd_cd=px_cd at n+1.
REQ-020 SHALL give pixel writes absolute priority; a px_write is never dropped or delayed.
REQ-021 SHALL run the host state machine with states IDLE, ISSUE, GAP.
REQ-022 IDLE->ISSUE SHALL occur when vblank=1, complete-group count>=1, px_write=0 and lcd_write=0 in the current cycle.
REQ-023 In ISSUE, if px_write=0 and lcd_write=0 the head byte SHALL be popped and driven (lcd_write=1 next cycle), then ->GAP; otherwise SHALL stay in ISSUE without popping.
REQ-024 GAP SHALL last exactly one cycle (guarantees an idle bus cycle between host writes); then ->IDLE if the issued byte had last=1, else ->ISSUE.
REQ-025 Once a group has started, remaining bytes SHALL be issued even if vblank falls (atomic group), still yielding per cycle to px_write.
REQ-026 A group SHALL never start unless its last byte is already in the FIFO.
REQ-027 lcd_data and lcd_cd SHALL hold their last driven value on cycles with lcd_write=0.
REQ-028 cmd_pending SHALL reflect FIFO occupancy registered state (not-empty), updated the cycle after accept/pop.
REQ-029 A cmd_valid with FIFO full SHALL not be accepted and SHALL leave the FIFO unchanged.

Reset
REQ-030 On reset: state=IDLE, FIFO empty, group count=0, lcd_write=0, lcd_data=0x00, lcd_cd=0, cmd_pending=0, cmd_ready=0 during reset and 1 the cycle after.
REQ-031 Reset mid-group SHALL discard all FIFO contents including a partially issued group; no lcd_write in the cycle after reset is asserted.

Verification
REQ-032 Pixel pass-through: vblank=0, px_write with px_data=0xA5, px_cd=1 at cycle n -> lcd_write=1, lcd_data=0xA5, lcd_cd=1 at n+1 only.
REQ-033 Host group: push {0,0,0x81},{0,1,0x00}, vblank=1 -> lcd_write pulses with 0x81/cd=0 then 0x00/cd=0, exactly one idle cycle between, cmd_pending=0 afterwards.
REQ-034 Incomplete group: push {0,0,0x81} only, vblank=1 for 50 cycles -> no lcd_write; push {0,1,0x46} -> both bytes issued.
REQ-035 Collision: host byte due in ISSUE while px_write=1 -> pixel byte appears next cycle, host byte appears at the first later cycle with bus free, none lost.
REQ-036 Full FIFO: push 5 bytes with vblank=0, FIFO_DEPTH=4 -> cmd_ready=0 after 4th accept, 5th byte held by host, accepted after first pop.
REQ-037 Reset mid-group: assert reset after first byte of a 2-byte group issued -> second byte never issued, cmd_pending=0, lcd_data=0x00.
